// File: rtl/ssd_scan_driver_pkg.sv
// ============================================================================
// ssd_scan_driver_pkg : segment decode constants, blanking values, clog2
// Revision 1.0
// ============================================================================
`default_nettype none

package ssd_scan_driver_pkg;

   // Segment patterns, bit order {a,b,c,d,e,f,g}, 0 = segment on
   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] ANODE_OFF = 8'hFF;

   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_hex_decode.sv
// ============================================================================
// ssd_hex_decode : 4-bit nibble to active-low {a..g} segment pattern
// Revision 1.0
// ============================================================================
`default_nettype none

module ssd_hex_decode
   import ssd_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
// ============================================================================
// ssd_scan_driver : multiplexed seven-segment scan with frame-synced shadowing
// Optional macro SSD_LZ_BLANK_EN enables leading-zero suppression.
// Revision 1.0
// ============================================================================
`default_nettype none

module ssd_scan_driver
   import ssd_scan_driver_pkg::*;
#(
   parameter  int NUM_DIGITS    = 8,
   parameter  int SCAN_DIV_BITS = 18,
   parameter  int BLANK_CYCLES  = 16,
   localparam int IDX_W         = clog2(NUM_DIGITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              cathodes,
   output logic [IDX_W-1:0]        scan_idx,
   output logic                    frame_tick
);

   localparam logic [SCAN_DIV_BITS-1:0] PRE_MAX   = '1;
   localparam logic [SCAN_DIV_BITS-1:0] PRE_LAST  = {{(SCAN_DIV_BITS-1){1'b1}}, 1'b0};
   localparam logic [SCAN_DIV_BITS-1:0] BLANK_LIM = SCAN_DIV_BITS'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0]    AN_OFF    = ANODE_OFF[NUM_DIGITS-1:0];

   logic [SCAN_DIV_BITS-1:0] prescaler;
   logic [4*NUM_DIGITS-1:0]  pend_val, disp_val;
   logic [NUM_DIGITS-1:0]    pend_dp, disp_dp;
   logic                     pend_valid;

   logic                     slot_end, last_digit, wrap;
   logic [3:0]               nib_sel;
   logic                     dp_sel, en_sel, keep_sel, lit;
   logic [NUM_DIGITS-1:0]    onehot_n, keep;
   logic [6:0]               seg;

   assign slot_end   = (prescaler == PRE_MAX);
   assign last_digit = (scan_idx == LAST_IDX);
   assign wrap       = slot_end & last_digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler  <= '0;
         scan_idx   <= '0;
         frame_tick <= 1'b0;
      end else begin
         prescaler <= prescaler + SCAN_DIV_BITS'(1);
         if (slot_end)
            scan_idx <= last_digit ? '0 : scan_idx + IDX_W'(1);
         // Pulse covers the cycle whose closing edge performs the wrap
         frame_tick <= (prescaler == PRE_LAST) & last_digit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
      end else begin
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         if (wrap) begin
            if (load) begin
               disp_val <= value;
               disp_dp  <= dp_in;
            end else if (pend_valid) begin
               disp_val <= pend_val;
               disp_dp  <= pend_dp;
            end
            pend_valid <= 1'b0;
         end else if (load) begin
            pend_valid <= 1'b1;
         end
      end
   end

`ifdef SSD_LZ_BLANK_EN
   // A digit survives if any nibble at or above it is nonzero, or its dp is lit
   always_comb begin
      logic seen;
      seen = 1'b0;
      keep = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         seen    = seen | (disp_val[4*i +: 4] != 4'h0);
         keep[i] = seen | disp_dp[i] | (i == 0);
      end
   end
`else
   assign keep = '1;
`endif

   always_comb begin
      nib_sel  = '0;
      dp_sel   = 1'b0;
      en_sel   = 1'b0;
      keep_sel = 1'b0;
      onehot_n = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            nib_sel     = disp_val[4*i +: 4];
            dp_sel      = disp_dp[i];
            en_sel      = digit_en[i];
            keep_sel    = keep[i];
            onehot_n[i] = 1'b0;
         end
      end
   end

   ssd_hex_decode u_dec (
      .nibble (nib_sel),
      .seg    (seg)
   );

   assign lit = (prescaler >= BLANK_LIM) & en_sel & keep_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an       <= AN_OFF;
         cathodes <= 8'hFF;
      end else begin
         an       <= lit ? onehot_n : AN_OFF;
         cathodes <= lit ? {seg, ~dp_sel} : {SEG_BLANK, 1'b1};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// ============================================================================
// tb_ssd_scan_driver : scoreboard bench, 4 digits, 16-cycle slots, 2 blank
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ssd_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = 4'hF;
   logic        load = 1'b0;
   logic [3:0]  an;
   logic [7:0]  cathodes;
   logic [1:0]  scan_idx;
   logic        frame_tick;

   ssd_scan_driver #(
      .NUM_DIGITS    (4),
      .SCAN_DIV_BITS (4),
      .BLANK_CYCLES  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .an         (an),
      .cathodes   (cathodes),
      .scan_idx   (scan_idx),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Edges since the last reset release; after edge k: prescaler=k%16, digit=(k/16)%4
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [7:0] cat;
      int         tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic       exp_ft;
   logic [1:0] exp_idx;

   task automatic expect_at(input int k, input logic [3:0] a, input logic [7:0] c, input int tag);
      exp_t e;
      e.cyc = k; e.an = a; e.cat = c; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] d);
      if (cyc >= k) begin
         errors++;
         $display("FAIL load_sched: now cyc %0d, required before %0d", cyc, k);
      end
      while (cyc < k - 1) @(negedge clk);
      value = v;
      dp_in = d;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Monitor: timing outputs every cycle, scoreboard entries at their cycle
   always @(negedge clk) begin
      if (!rst) begin
         exp_ft  = (cyc % 64 == 63);
         exp_idx = 2'((cyc / 16) % 4);
         checks++;
         if (frame_tick !== exp_ft) begin
            errors++;
            $display("FAIL frame_tick cyc %0d: got %b, required %b", cyc, frame_tick, exp_ft);
         end
         checks++;
         if (scan_idx !== exp_idx) begin
            errors++;
            $display("FAIL scan_idx cyc %0d: got %0d, required %0d", cyc, scan_idx, exp_idx);
         end
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            errors++;
            $display("FAIL missed_check tag %0d at cyc %0d", sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            checks++;
            if (an !== sb[0].an || cathodes !== sb[0].cat) begin
               errors++;
               $display("FAIL slot tag %0d cyc %0d: got an=%b cat=%b, required an=%b cat=%b",
                        sb[0].tag, cyc, an, cathodes, sb[0].an, sb[0].cat);
            end
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Outputs are lit (digit 2 showing 0) before the mid-slot reset
      while (cyc < 40) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (an !== 4'hF || cathodes !== 8'hFF || scan_idx !== 2'd0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got an=%h cat=%h idx=%0d ft=%b, required an=f cat=ff idx=0 ft=0",
                  an, cathodes, scan_idx, frame_tick);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Frame 0: display registers hold zeros
      expect_at(1,  4'hF,    8'hFF, 1);
      expect_at(20, 4'b1101, 8'h03, 2);

      // Load 1234 in frame 0; shown in frame 1
      do_load(10, 16'h1234, 4'b0000);
      expect_at(65, 4'hF,    8'hFF, 10);
      expect_at(66, 4'hF,    8'hFF, 11);
      expect_at(67, 4'b1110, 8'h99, 12);
      expect_at(70, 4'b1110, 8'h99, 13);
      expect_at(82, 4'hF,    8'hFF, 14);
      expect_at(86, 4'b1101, 8'h0D, 15);

      // Mid-frame load stays pending until the wrap
      do_load(99, 16'hABCD, 4'b0000);
      expect_at(103, 4'b1011, 8'h25, 20);
      expect_at(119, 4'b0111, 8'h9F, 21);
      expect_at(135, 4'b1110, 8'h85, 22);
      expect_at(183, 4'b0111, 8'h11, 23);

      // Load on the frame_tick cycle takes effect at that very wrap
      do_load(192, 16'h5555, 4'b0000);
      expect_at(201, 4'b1110, 8'h49, 30);
      expect_at(217, 4'b1101, 8'h49, 31);
      expect_at(233, 4'b1011, 8'h49, 32);
      expect_at(249, 4'b0111, 8'h49, 33);

      // Frame 4: 0070 with dp on digit 0, digits 1 and 3 disabled
      do_load(200, 16'h0070, 4'b0001);
      while (cyc < 250) @(negedge clk);
      digit_en = 4'b0101;
      expect_at(265, 4'b1110, 8'h02, 40);
      expect_at(276, 4'hF,    8'hFF, 41);
      expect_at(281, 4'hF,    8'hFF, 42);
`ifdef SSD_LZ_BLANK_EN
      expect_at(297, 4'hF,    8'hFF, 43);
`else
      expect_at(297, 4'b1011, 8'h03, 43);
`endif
      expect_at(313, 4'hF,    8'hFF, 44);

      // Frame 5: all digits enabled, leading-zero behaviour visible
      while (cyc < 316) @(negedge clk);
      digit_en = 4'hF;
      expect_at(329, 4'b1110, 8'h02, 50);
      expect_at(345, 4'b1101, 8'h1F, 51);
`ifdef SSD_LZ_BLANK_EN
      expect_at(361, 4'hF,    8'hFF, 52);
      expect_at(377, 4'hF,    8'hFF, 53);
`else
      expect_at(361, 4'b1011, 8'h03, 52);
      expect_at(377, 4'b0111, 8'h03, 53);
`endif

      while (cyc < 390) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
